// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port program/data memory.
// Port 0 has fixed priority, and port 1 is forced through after MAX_WAIT refused cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    // port 0: processor fetch/operand path
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // port 1: loader/debug port
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // memory side
    output logic [ADDR_W-1:0] memAddr,
    output logic              memStrobe,
    output logic              memWrite,
    output logic [DATA_W-1:0] memDataWrite,
    input  logic [DATA_W-1:0] memDataRead
);

    localparam int unsigned   CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    // Read-return tag: which port owns the data arriving from memory this cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_P0   = 2'b01,
        TAG_P1   = 2'b10
    } rdTag_t;

    rdTag_t            rdTag;
    rdTag_t            rdTagNext;
    logic [CNT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]  waitCntNext;
    logic              force1;
    logic              grant0;
    logic              grant1;
    logic [DATA_W-1:0] rdHold0;
    logic [DATA_W-1:0] rdHold1;

    // Arbitration; both grants are held low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        force1 = (waitCnt >= WAIT_LIMIT);
        if (resetn) begin
            grant1 = req1 & (~req0 | force1);
            grant0 = req0 & ~grant1;
        end
    end

    assign gnt0 = grant0;
    assign gnt1 = grant1;

    // Memory drive follows the granted port, defaulting to port 0 when idle.
    always_comb begin
        memStrobe    = grant0 | grant1;
        memAddr      = addr0;
        memWrite     = resetn & we0;
        memDataWrite = wdata0;
        if (grant1) begin
            memAddr      = addr1;
            memWrite     = we1;
            memDataWrite = wdata1;
        end
    end

    // Next-state: return tag and port 1 starvation counter.
    always_comb begin
        rdTagNext   = TAG_NONE;
        waitCntNext = waitCnt;
        if (grant0 && !we0) begin
            rdTagNext = TAG_P0;
        end else if (grant1 && !we1) begin
            rdTagNext = TAG_P1;
        end
        if (!req1 || grant1) begin
            waitCntNext = '0;
        end else if (waitCnt != CNT_MAX) begin
            waitCntNext = waitCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdTag   <= TAG_NONE;
            waitCnt <= '0;
        end else begin
            rdTag   <= rdTagNext;
            waitCnt <= waitCntNext;
        end
    end

    assign rvalid0 = (rdTag == TAG_P0);
    assign rvalid1 = (rdTag == TAG_P1);

    // Hold registers keep the last returned word visible between reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdHold0 <= '0;
            rdHold1 <= '0;
        end else begin
            if (rvalid0) begin
                rdHold0 <= memDataRead;
            end
            if (rvalid1) begin
                rdHold1 <= memDataRead;
            end
        end
    end

    assign rdata0 = rvalid0 ? memDataRead : rdHold0;
    assign rdata1 = rvalid1 ? memDataRead : rdHold1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 256x8 synchronous memory model plus a read-return scoreboard.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req0, we0, gnt0, rvalid0;
    logic [7:0] addr0, wdata0, rdata0;
    logic       req1, we1, gnt1, rvalid1;
    logic [7:0] addr1, wdata1, rdata1;
    logic [7:0] memAddr, memDataWrite, memDataRead;
    logic       memStrobe, memWrite;

    logic [7:0] memArray [256];
    logic [7:0] refMem   [256];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       pend0 = 1'b0;
    logic       pend1 = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .memAddr(memAddr), .memStrobe(memStrobe), .memWrite(memWrite),
        .memDataWrite(memDataWrite), .memDataRead(memDataRead)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory with 1-cycle read latency.
    always @(posedge clk) begin
        if (memStrobe) begin
            if (memWrite) memArray[memAddr] <= memDataWrite;
            else          memDataRead <= memArray[memAddr];
        end
    end

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Scoreboard: expected read data is queued when a read is granted and compared on rvalid.
    always @(negedge clk) begin
        if (!resetn) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
            q0.delete();
            q1.delete();
            vectors++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                miscompares++;
                $display("FAIL rvalid_in_reset: got %b%b want 00", rvalid0, rvalid1);
            end
        end else begin
            vectors++;
            if (rvalid0 !== pend0 || rvalid1 !== pend1) begin
                miscompares++;
                $display("FAIL sb_rvalid: got %b%b want %b%b", rvalid0, rvalid1, pend0, pend1);
            end
            if (pend0 && rvalid0 === 1'b1) begin
                logic [7:0] e0;
                e0 = q0.pop_front();
                vectors++;
                if (rdata0 !== e0) begin
                    miscompares++;
                    $display("FAIL sb_rdata0: got %h want %h", rdata0, e0);
                end
            end
            if (pend1 && rvalid1 === 1'b1) begin
                logic [7:0] e1;
                e1 = q1.pop_front();
                vectors++;
                if (rdata1 !== e1) begin
                    miscompares++;
                    $display("FAIL sb_rdata1: got %h want %h", rdata1, e1);
                end
            end
            vectors++;
            if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
                miscompares++;
                $display("FAIL both_grants: got 11 want at most one");
            end
            pend0 = (gnt0 === 1'b1) && !we0;
            pend1 = (gnt1 === 1'b1) && !we1;
            if (pend0) q0.push_back(refMem[addr0]);
            if (pend1) q1.push_back(refMem[addr1]);
            if (gnt0 === 1'b1 && we0) refMem[addr0] = wdata0;
            if (gnt1 === 1'b1 && we1) refMem[addr1] = wdata1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 8'hFF;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h06; wdata1 = 8'hEE;
        @(negedge clk);
        vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
        vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL rst_gnt1: got %b want 0", gnt1); end
        vectors++; if (memStrobe !== 1'b0) begin miscompares++; $display("FAIL rst_strobe: got %b want 0", memStrobe); end
        vectors++; if (memWrite !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b want 0", memWrite); end
        vectors++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin miscompares++; $display("FAIL rst_rdata: got %h %h want 00 00", rdata0, rdata1); end
        step();
        idle();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_port0_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(negedge clk);
        vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL p0rd_gnt: got %b%b want 10", gnt0, gnt1); end
        vectors++; if (memStrobe !== 1'b1 || memWrite !== 1'b0) begin miscompares++; $display("FAIL p0rd_mem: got %b%b want 10", memStrobe, memWrite); end
        vectors++; if (memAddr !== 8'h10) begin miscompares++; $display("FAIL p0rd_addr: got %h want 10", memAddr); end
        step();
        idle();
        @(negedge clk);
        vectors++; if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin miscompares++; $display("FAIL p0rd_data: got %b %h want 1 a5", rvalid0, rdata0); end
        vectors++; if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL p0rd_rvalid1: got %b want 0", rvalid1); end
        step();
        @(negedge clk);
        vectors++; if (rvalid0 !== 1'b0 || rdata0 !== 8'hA5) begin miscompares++; $display("FAIL p0rd_hold: got %b %h want 0 a5", rvalid0, rdata0); end
        step();
    endtask

    task automatic test_port1_write();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
        @(negedge clk);
        vectors++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin miscompares++; $display("FAIL p1wr_gnt: got %b%b want 01", gnt0, gnt1); end
        vectors++; if (memStrobe !== 1'b1 || memWrite !== 1'b1) begin miscompares++; $display("FAIL p1wr_mem: got %b%b want 11", memStrobe, memWrite); end
        vectors++; if (memAddr !== 8'h20 || memDataWrite !== 8'h3C) begin miscompares++; $display("FAIL p1wr_bus: got %h %h want 20 3c", memAddr, memDataWrite); end
        step();
        idle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        @(negedge clk);
        vectors++; if (gnt0 !== 1'b1 || rvalid1 !== 1'b0) begin miscompares++; $display("FAIL p1wr_nowrrvalid: got %b %b want 1 0", gnt0, rvalid1); end
        step();
        idle();
        @(negedge clk);
        vectors++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h3C) begin miscompares++; $display("FAIL p1wr_readback: got %b %h want 1 3c", rvalid0, rdata0); end
        step();
    endtask

    task automatic test_contention();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
        for (int i = 0; i < 10; i++) begin
            logic e1;
            e1 = (i % 5 == 4);
            @(negedge clk);
            vectors++;
            if (gnt1 !== e1 || gnt0 !== !e1) begin
                miscompares++;
                $display("FAIL contention_c%0d: got %b%b want %b%b", i, gnt0, gnt1, !e1, e1);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = 8'(i);
            end else begin
                idle();
            end
            @(negedge clk);
            if (i < 3) begin
                vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL b2b_gnt%0d: got %b want 1", i, gnt0); end
            end
            if (i > 0) begin
                vectors++;
                if (rvalid0 !== 1'b1 || rdata0 !== pat(8'(i - 1))) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got %b %h want 1 %h", i - 1, rvalid0, rdata0, pat(8'(i - 1)));
                end
            end
            step();
        end
        @(negedge clk);
        vectors++; if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", rvalid0); end
        step();
    endtask

    task automatic test_interleave();
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
        @(negedge clk);
        vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL il_gnt1: got %b want 1", gnt1); end
        step();
        idle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h41;
        @(negedge clk);
        vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL il_gnt0: got %b want 1", gnt0); end
        vectors++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== 8'h1A) begin miscompares++; $display("FAIL il_ret1: got %b%b %h want 01 1a", rvalid0, rvalid1, rdata1); end
        step();
        idle();
        @(negedge clk);
        vectors++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 8'h1B) begin miscompares++; $display("FAIL il_ret0: got %b%b %h want 10 1b", rvalid0, rvalid1, rdata0); end
        step();
    endtask

    task automatic test_drop();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h50;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h51;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL drop_pre%0d: got %b want 0", i, gnt1); end
            step();
        end
        req1 = 1'b0;
        @(negedge clk);
        vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL drop_gap: got %b%b want 10", gnt0, gnt1); end
        step();
        req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (gnt1 !== (i == 4)) begin
                miscompares++;
                $display("FAIL drop_post%0d: got %b want %b", i, gnt1, (i == 4));
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h60;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h61;
        step();
        step();
        addr0 = 8'h62;
        @(negedge clk);
        vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL rmr_gnt: got %b want 1", gnt0); end
        #1 resetn = 1'b0;
        #1;
        vectors++; if (gnt0 !== 1'b0 || memStrobe !== 1'b0) begin miscompares++; $display("FAIL rmr_forced: got %b%b want 00", gnt0, memStrobe); end
        step();
        idle();
        step();
        resetn = 1'b1;
        @(negedge clk);
        vectors++; if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL rmr_norvalid: got %b want 0", rvalid0); end
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h70;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h71;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (gnt1 !== (i == 4) || gnt0 !== (i != 4)) begin
                miscompares++;
                $display("FAIL rmr_arb%0d: got %b%b want %b%b", i, gnt0, gnt1, (i != 4), (i == 4));
            end
            step();
        end
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            memArray[i] = pat(8'(i));
            refMem[i]   = pat(8'(i));
        end
        memArray[8'h10] = 8'hA5;
        refMem[8'h10]   = 8'hA5;
        memDataRead = 8'h00;
        resetn = 1'b0;
        addr0 = 8'h00; wdata0 = 8'h00;
        addr1 = 8'h00; wdata1 = 8'h00;
        idle();

        test_reset();
        test_port0_read();
        test_port1_write();
        test_contention();
        test_back_to_back();
        test_interleave();
        test_drop();
        test_reset_mid_read();

        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d %0d want 0 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
